// File: rtl/arbiter_sync_sink.sv
// arbiter_sync_sink: clocked sink for the tree arbiter's 4-phase
// bundled-data channel. Synchronises req, buffers sel in a FIFO, returns ack.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_in, sel_in      4-phase request and bundled selection index
//   ack_out             registered 4-phase acknowledge
//   out_valid/out_ready valid/ready read side, out_addr = FIFO head
//   fifo_count          current occupancy
//   evt_count           captured events, wraps modulo 2^16
module arbiter_sync_sink #(
   parameter int SEL_BITS    = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_in,
   output logic                          ack_out,
   input  logic [SEL_BITS-1:0]           sel_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SEL_BITS-1:0]           out_addr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [15:0]                   evt_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACK_HI = 1'b1
   } state_t;

   state_t                    r_state;
   logic [SYNC_STAGES-1:0]    r_sync;
   logic [SEL_BITS-1:0]       r_mem [FIFO_DEPTH];
   logic [PW-1:0]             r_wr;
   logic [PW-1:0]             r_rd;
   logic [CW-1:0]             r_count;
   logic [15:0]               r_evt;
   logic                      r_ack;

   logic                      w_req_s;
   logic                      w_full;
   logic                      w_push;
   logic                      w_pop;

   assign w_req_s = r_sync[SYNC_STAGES-1];
   // Full uses the registered count: a same-cycle pop never frees a slot.
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_push  = (r_state == IDLE) && w_req_s && !w_full;
   assign w_pop   = (r_count != '0) && out_ready;

   // Only req crosses domains; sel is stable whenever req_s is seen high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], req_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ack   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_push) begin
                  r_ack   <= 1'b1;
                  r_state <= ACK_HI;
               end
            end
            ACK_HI: begin
               if (!w_req_s) begin
                  r_ack   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_ack   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_evt   <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= sel_in;
            r_wr        <= r_wr + 1'b1;
            r_evt       <= r_evt + 16'd1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign ack_out    = r_ack;
   assign out_valid  = (r_count != '0);
   assign out_addr   = r_mem[r_rd];
   assign fifo_count = r_count;
   assign evt_count  = r_evt;

endmodule

// File: tb/tb_arbiter_sync_sink.sv
// tb_arbiter_sync_sink: scoreboard bench for arbiter_sync_sink.
// Driver issues 4-phase handshakes; a negedge monitor checks against a queue model.
module tb_arbiter_sync_sink;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_in = 1'b0;
   logic        ack_out;
   logic [3:0]  sel_in = 4'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_addr;
   logic [2:0]  fifo_count;
   logic [15:0] evt_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0]  q[$];
   logic [15:0] m_evt = 16'd0;
   logic        prev_ack = 1'b0;
   int          prev_occ = 0;
   bit          rnd_done = 1'b0;

   arbiter_sync_sink #(
      .SEL_BITS(4),
      .FIFO_DEPTH(DEPTH),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_in(req_in),
      .ack_out(ack_out),
      .sel_in(sel_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_addr(out_addr),
      .fifo_count(fifo_count),
      .evt_count(evt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // Monitor / scoreboard: a capture is an ack rising edge; the head must
   // follow capture order and occupancy must equal the model queue size.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_evt    = 16'd0;
         prev_ack = 1'b0;
         prev_occ = 0;
      end else begin
         if (ack_out && !prev_ack) begin
            chk("ack_while_full", 32'(prev_occ < DEPTH), 32'd1);
            q.push_back(sel_in);
            m_evt = m_evt + 16'd1;
         end
         prev_ack = ack_out;
         chk("fifo_count", 32'(fifo_count), 32'(q.size()));
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("evt_count", 32'(evt_count), 32'(m_evt));
         if (q.size() != 0) chk("out_addr", 32'(out_addr), 32'(q[0]));
         prev_occ = q.size();
         if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      end
   end

   task automatic wait_ack(input logic v, input string n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (ack_out === v) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({n, "_timeout"}, 32'(ack_out), 32'(v));
   endtask

   task automatic hs(input logic [3:0] s);
      sel_in = s;
      req_in = 1'b1;
      wait_ack(1'b1, "ack_rise");
      req_in = 1'b0;
      wait_ack(1'b0, "ack_fall");
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 50 && out_valid; i++) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(out_valid), 32'd0);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack_out), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_evt", 32'(evt_count), 32'd0);
      chk("rst_addr", 32'(out_addr), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single event with latency checks
      sel_in = 4'hA;
      req_in = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      chk("lat_ack_early", 32'(ack_out), 32'd0);
      @(posedge clk); #1;
      chk("lat_ack", 32'(ack_out), 32'd1);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_addr", 32'(out_addr), 32'hA);
      req_in = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("fall_early", 32'(ack_out), 32'd1);
      @(posedge clk); #1;
      chk("fall_ack", 32'(ack_out), 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("single_pop_valid", 32'(out_valid), 32'd0);
      chk("single_evt", 32'(evt_count), 32'd1);

      // burst in order
      hs(4'h3); hs(4'h7); hs(4'h1); hs(4'hE);
      chk("burst_count", 32'(fifo_count), 32'd4);
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("burst_empty", 32'(out_valid), 32'd0);

      // full backpressure
      hs(4'h2); hs(4'h4); hs(4'h6); hs(4'h8);
      sel_in = 4'h5;
      req_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("bp_hold", 32'(ack_out), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_pop_no_bypass", 32'(ack_out), 32'd0);
      @(posedge clk); #1;
      chk("bp_ack", 32'(ack_out), 32'd1);
      chk("bp_count", 32'(fifo_count), 32'd4);
      req_in = 1'b0;
      wait_ack(1'b0, "bp_fall");
      drain();

      // simultaneous push and pop
      hs(4'hB); hs(4'hC);
      sel_in = 4'h9;
      req_in = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("pp_ack", 32'(ack_out), 32'd1);
      chk("pp_count", 32'(fifo_count), 32'd2);
      req_in = 1'b0;
      wait_ack(1'b0, "pp_fall");
      drain();

      // reset mid-handshake
      hs(4'hD);
      sel_in = 4'hF;
      req_in = 1'b1;
      wait_ack(1'b1, "mr_rise");
      rst_n = 1'b0;
      #1;
      chk("mr_ack", 32'(ack_out), 32'd0);
      chk("mr_count", 32'(fifo_count), 32'd0);
      chk("mr_evt", 32'(evt_count), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_ack(1'b1, "mr_recap");
      chk("mr_recap_count", 32'(fifo_count), 32'd1);
      req_in = 1'b0;
      wait_ack(1'b0, "mr_fall");
      drain();

      // evt_count wrap via preload
      force dut.r_evt = 16'hFFFF;
      m_evt = 16'hFFFF;
      @(posedge clk); #1;
      release dut.r_evt;
      @(posedge clk); #1;
      chk("wrap_pre", 32'(evt_count), 32'hFFFF);
      hs(4'h1);
      chk("wrap_evt", 32'(evt_count), 32'd0);
      drain();

      // randomized traffic
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               hs(4'($urandom));
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #0;
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 1) == 1);
            end
         end
      join
      @(posedge clk); #1;
      drain();

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/arbiter_sync_sink.md
Name: arbiter_sync_sink

Overview:
- Downstream consumer of the tree arbiter's output channel.
- Receives the 4-phase bundled-data handshake (req, sel) from the arbiter root and synchronises req into the clocked domain.
- Captures the selection index into a small FIFO and completes the handshake via ack.
- Presents the captured indices to clocked logic on a valid/ready interface, where they serve as memory addresses.

Parameters:
- SEL_BITS, 4, width of the selection index from the arbiter.
- FIFO_DEPTH, 4, number of buffered indices; power of two, at least 2.
- SYNC_STAGES, 2, flip-flops in the req synchroniser; at least 2.

Ports:
- clk  input  1  single clock for all state.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_in  input  1  4-phase request from the arbiter root; asynchronous to clk.
- ack_out  output  1  4-phase acknowledge back to the arbiter root; registered.
- sel_in  input  SEL_BITS  selection index, bundled with req_in; stable while req_in is high.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry.
- out_addr  output  SEL_BITS  FIFO head entry; valid when out_valid is 1.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
- evt_count  output  16  total captured events; wraps modulo 2^16.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ack_out=0, out_valid=0, fifo_count=0, evt_count=0, out_addr=0.
  - Synchroniser cleared; FSM goes to IDLE; read and write pointers go to 0.
- Synchroniser: req_s is req_in after SYNC_STAGES flops. sel_in is never synchronised; it is sampled only when req_s=1, which bundled-data timing makes safe.
- FSM, two states:
  - IDLE: ack_out=0.
    - req_s=1 and fifo_count<FIFO_DEPTH: on that edge write sel_in at wr_ptr, wr_ptr+1, evt_count+1, ack_out<=1, go to ACK_HI.
    - req_s=1 and FIFO full: stay in IDLE, ack withheld. This is the backpressure to the arbiter; no event is dropped.
  - ACK_HI: ack_out=1.
    - req_s=0: ack_out<=0, go to IDLE.
    - req_s=1: hold.
- Full check uses the registered fifo_count; a pop in the same cycle does not free a slot for that cycle's push (no bypass).
- Output side:
  - out_valid = (fifo_count!=0); out_addr = mem[rd_ptr], combinational from registered state.
  - Pop when out_valid and out_ready: rd_ptr+1.
  - out_ready while empty has no effect.
- Occupancy: push and pop in the same cycle leaves fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
- Latency: first edge sampling req_in=1 is edge E. ack_out and out_valid (empty FIFO) rise after edge E+SYNC_STAGES. ack_out falls after edge F+SYNC_STAGES, where F is the first edge sampling req_in=0.
- Handshake rules:
  - Exactly one FIFO write per req rising phase.
  - A new event is accepted only after a full return-to-zero (req low seen, ack low driven).
  - req_in glitch-free 4-phase behaviour from upstream is required.
- Reset mid-operation:
  - Buffered entries are lost; ack_out drops immediately.
  - If req_in is still high after release, the event is captured again; upstream must be reset together with this block.
- evt_count wraps from 0xFFFF to 0x0000 without a flag.

Test Plan:
- Single event: reset, sel_in=4'hA, req_in=1 → ack_out=1 and out_valid=1, out_addr=4'hA after 2 edges. Drop req_in → ack_out=0 two edges later. Pop → out_valid=0, evt_count=1.
- Burst in order: 4 handshakes with sel 3,7,1,E, out_ready=0 → fifo_count=4, out_valid=1. Then out_ready=1 → out_addr reads 3,7,1,E on consecutive cycles, then out_valid=0.
- Full backpressure: fill 4 entries, start 5th handshake with sel=5 → ack_out stays 0 while out_ready=0. Single pop → ack_out rises 1 edge later, 5 becomes the 4th entry, fifo_count=4.
- Simultaneous push/pop: fifo_count=2, push completes on the same edge as a pop → fifo_count stays 2, order preserved.
- Reset mid-handshake: assert rst_n=0 while in ACK_HI with 2 entries → ack_out=0 and fifo_count=0 immediately, evt_count=0. Release with req_in still high → one re-capture, fifo_count=1.
- Counter wrap: force 65536 handshakes, or preload evt_count=0xFFFF in the bench → next capture gives evt_count=0x0000.
